// File: rtl/host_cmd_pkg.sv
// host_cmd_pkg: opcodes, per-opcode length table and FSM states
// shared by the host UART command decoder and its dword packer.
package host_cmd_pkg;

    localparam logic [7:0] SOF_DEFAULT  = 8'h55;

    localparam logic [7:0] OPC_WR_BLOCK = 8'h01;
    localparam logic [7:0] OPC_SET_TGT  = 8'h02;
    localparam logic [7:0] OPC_STATUS   = 8'h03;
    localparam logic [7:0] OPC_BREAK    = 8'h04;
    localparam logic [7:0] OPC_RECONFIG = 8'h05;

    typedef enum logic [2:0] {
        S_HUNT,
        S_OPC,
        S_LEN,
        S_PAY,
        S_CHK
    } state_t;

    function automatic logic opc_known(input logic [7:0] opc);
        return (opc >= OPC_WR_BLOCK) && (opc <= OPC_RECONFIG);
    endfunction

    // Only this many payload dwords is accepted for each opcode
    function automatic logic [7:0] req_len(input logic [7:0] opc);
        case (opc)
            OPC_WR_BLOCK: return 8'd20;
            OPC_SET_TGT:  return 8'd8;
            OPC_RECONFIG: return 8'd1;
            default:      return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/host_dword_packer.sv
// host_dword_packer: collects payload bytes LSB-first into 32-bit
// dwords and strobes each completed dword for one cycle.
module host_dword_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        dword_en,
    output logic [31:0] dword
);

    logic [1:0]  lane;
    logic [23:0] sr;

    // Shift bytes in; the fourth byte completes the dword directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane     <= 2'd0;
            sr       <= 24'd0;
            dword_en <= 1'b0;
            dword    <= 32'd0;
        end else begin
            dword_en <= 1'b0;
            if (clr) begin
                lane <= 2'd0;
            end else if (byte_valid) begin
                lane <= lane + 2'd1;
                if (lane == 2'd3) begin
                    dword    <= {byte_in, sr};
                    dword_en <= 1'b1;
                end else begin
                    sr <= {byte_in, sr[23:8]};
                end
            end
        end
    end

endmodule

// File: rtl/host_cmd_decoder.sv
// host_cmd_decoder: frames host UART bytes into commands and dwords.
// Define HOST_CMD_CHKSUM_EN to require a trailing XOR checksum byte.
module host_cmd_decoder
    import host_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 100000,
    parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
    parameter int         MAX_DWORDS  = 63
) (
    input  logic        clk_h,
    input  logic        rst_h,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        wr_block,
    output logic        set_target,
    output logic        status_go,
    output logic        host_break,
    output logic        go_reconfig,
    output logic [7:0]  hash_frequency,
    output logic        uart_cou_dword_en,
    output logic [31:0] data_from_host,
    output logic        link_rx_wr_cmplt,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

    state_t      state;
    logic [7:0]  opc;
    logic [9:0]  byte_cnt;
    logic [9:0]  last_idx;
    logic [7:0]  hash_tmp;
    logic [31:0] tmo_cnt;
    logic        tmo_hit;
    logic        len_bad;
    logic        cmplt_d1;
    logic        cmplt_d2;
    logic        err_req;
    logic        pack_clr;
    logic        pack_en;
`ifdef HOST_CMD_CHKSUM_EN
    logic [7:0]  chk;
`endif

    assign tmo_hit  = (state != S_HUNT) && !rx_valid
                   && (tmo_cnt == 32'(TIMEOUT_CYC - 1));
    assign len_bad  = (rx_byte != req_len(opc))
                   || ({24'd0, rx_byte} > 32'(MAX_DWORDS));
    assign pack_clr = rx_valid && (state == S_LEN);
    assign pack_en  = rx_valid && (state == S_PAY)
                   && (opc != OPC_RECONFIG);

    host_dword_packer u_packer (
        .clk        (clk_h),
        .rst        (rst_h),
        .clr        (pack_clr),
        .byte_valid (pack_en),
        .byte_in    (rx_byte),
        .dword_en   (uart_cou_dword_en),
        .dword      (data_from_host)
    );

    // Frame FSM; frame_err lags its cause by one cycle so it can never
    // land on the completion pulse of the frame just finished.
    always_ff @(posedge clk_h or posedge rst_h) begin
        if (rst_h) begin
            state            <= S_HUNT;
            opc              <= 8'd0;
            byte_cnt         <= 10'd0;
            last_idx         <= 10'd0;
            hash_tmp         <= 8'd0;
            tmo_cnt          <= 32'd0;
            cmplt_d1         <= 1'b0;
            cmplt_d2         <= 1'b0;
            err_req          <= 1'b0;
            wr_block         <= 1'b0;
            set_target       <= 1'b0;
            status_go        <= 1'b0;
            host_break       <= 1'b0;
            go_reconfig      <= 1'b0;
            hash_frequency   <= 8'h00;
            link_rx_wr_cmplt <= 1'b0;
            frame_err        <= 1'b0;
            err_cnt          <= 8'd0;
`ifdef HOST_CMD_CHKSUM_EN
            chk              <= 8'd0;
`endif
        end else begin
            wr_block         <= 1'b0;
            set_target       <= 1'b0;
            status_go        <= 1'b0;
            host_break       <= 1'b0;
            go_reconfig      <= 1'b0;
            cmplt_d1         <= 1'b0;
            cmplt_d2         <= cmplt_d1;
            link_rx_wr_cmplt <= cmplt_d2;
            err_req          <= 1'b0;
            frame_err        <= err_req;
            if (err_req && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;

            if (rx_valid || (state == S_HUNT))
                tmo_cnt <= 32'd0;
            else
                tmo_cnt <= tmo_cnt + 32'd1;

            if (tmo_hit) begin
                err_req <= 1'b1;
                state   <= S_HUNT;
            end else if (rx_valid) begin
                unique case (state)
                    S_HUNT: begin
                        if (rx_byte == SOF_BYTE)
                            state <= S_OPC;
                    end
                    S_OPC: begin
                        if (opc_known(rx_byte)) begin
                            opc   <= rx_byte;
                            state <= S_LEN;
`ifdef HOST_CMD_CHKSUM_EN
                            chk   <= rx_byte;
`endif
                        end else begin
                            err_req <= 1'b1;
                            state   <= S_HUNT;
                        end
                    end
                    S_LEN: begin
                        if (len_bad) begin
                            err_req <= 1'b1;
                            state   <= S_HUNT;
                        end else begin
                            byte_cnt   <= 10'd0;
                            last_idx   <= {rx_byte, 2'b00} - 10'd1;
                            wr_block   <= (opc == OPC_WR_BLOCK);
                            set_target <= (opc == OPC_SET_TGT);
`ifdef HOST_CMD_CHKSUM_EN
                            chk        <= chk ^ rx_byte;
                            state      <= (rx_byte == 8'd0) ? S_CHK : S_PAY;
`else
                            status_go  <= (opc == OPC_STATUS);
                            host_break <= (opc == OPC_BREAK);
                            state      <= (rx_byte == 8'd0) ? S_HUNT : S_PAY;
`endif
                        end
                    end
                    S_PAY: begin
                        byte_cnt <= byte_cnt + 10'd1;
                        if (byte_cnt == 10'd0)
                            hash_tmp <= rx_byte;
`ifdef HOST_CMD_CHKSUM_EN
                        chk <= chk ^ rx_byte;
                        if (byte_cnt == last_idx)
                            state <= S_CHK;
`else
                        if (byte_cnt == last_idx) begin
                            if (opc == OPC_RECONFIG) begin
                                hash_frequency <= hash_tmp;
                                go_reconfig    <= 1'b1;
                            end else begin
                                cmplt_d1 <= 1'b1;
                            end
                            state <= S_HUNT;
                        end
`endif
                    end
                    S_CHK: begin
`ifdef HOST_CMD_CHKSUM_EN
                        if (rx_byte == chk) begin
                            case (opc)
                                OPC_STATUS: status_go  <= 1'b1;
                                OPC_BREAK:  host_break <= 1'b1;
                                OPC_RECONFIG: begin
                                    hash_frequency <= hash_tmp;
                                    go_reconfig    <= 1'b1;
                                end
                                default:    cmplt_d2   <= 1'b1;
                            endcase
                        end else begin
                            err_req <= 1'b1;
                        end
`endif
                        state <= S_HUNT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_host_cmd_decoder.sv
// tb_host_cmd_decoder: scoreboard bench for host_cmd_decoder.
// Expected dwords/hash codes are queued at stimulus time, popped on output.
`timescale 1ns/1ps
module tb_host_cmd_decoder;

    localparam int TMO = 64;

    logic        clk_h = 1'b0;
    logic        rst_h = 1'b1;
    logic [7:0]  rx_byte = 8'd0;
    logic        rx_valid = 1'b0;
    logic        wr_block, set_target, status_go, host_break, go_reconfig;
    logic [7:0]  hash_frequency;
    logic        uart_cou_dword_en;
    logic [31:0] data_from_host;
    logic        link_rx_wr_cmplt, frame_err;
    logic [7:0]  err_cnt;

    host_cmd_decoder #(.TIMEOUT_CYC(TMO)) dut (
        .clk_h             (clk_h),
        .rst_h             (rst_h),
        .rx_byte           (rx_byte),
        .rx_valid          (rx_valid),
        .wr_block          (wr_block),
        .set_target        (set_target),
        .status_go         (status_go),
        .host_break        (host_break),
        .go_reconfig       (go_reconfig),
        .hash_frequency    (hash_frequency),
        .uart_cou_dword_en (uart_cou_dword_en),
        .data_from_host    (data_from_host),
        .link_rx_wr_cmplt  (link_rx_wr_cmplt),
        .frame_err         (frame_err),
        .err_cnt           (err_cnt)
    );

    always #5 clk_h = ~clk_h;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_dw_cyc = -100;
    int hdr_cyc = 0;
    int first_dw_cyc = 0;
    int n_dw, n_wr, n_st, n_status, n_brk, n_rcf, n_cmplt, n_err;
    int exp_err_cnt = 0;
    logic [31:0] exp_dw[$];
    logic [7:0]  exp_hash[$];
    logic [7:0]  pay[$];

    task automatic clr_counts();
        n_dw = 0; n_wr = 0; n_st = 0; n_status = 0;
        n_brk = 0; n_rcf = 0; n_cmplt = 0; n_err = 0;
    endtask

    // Output monitor: scoreboard pops and per-pulse bookkeeping
    task automatic sample();
        logic [31:0] e;
        logic [7:0]  h;
        cyc++;
        if (wr_block || set_target) hdr_cyc = cyc;
        if (wr_block) n_wr++;
        if (set_target) n_st++;
        if (status_go) n_status++;
        if (host_break) n_brk++;
        if (uart_cou_dword_en) begin
            n_dw++;
            if (n_dw == 1) first_dw_cyc = cyc;
            last_dw_cyc = cyc;
            checks++;
            if (exp_dw.size() == 0) begin
                errors++;
                $display("FAIL dword_unexpected got=%h", data_from_host);
            end else begin
                e = exp_dw.pop_front();
                if (data_from_host !== e) begin
                    errors++;
                    $display("FAIL dword got=%h exp=%h", data_from_host, e);
                end
            end
        end
        if (go_reconfig) begin
            n_rcf++;
            checks++;
            if (exp_hash.size() == 0) begin
                errors++;
                $display("FAIL reconfig_unexpected hash=%h", hash_frequency);
            end else begin
                h = exp_hash.pop_front();
                if (hash_frequency !== h) begin
                    errors++;
                    $display("FAIL hash got=%h exp=%h", hash_frequency, h);
                end
            end
        end
        if (link_rx_wr_cmplt) begin
            n_cmplt++;
            checks++;
            if (cyc - last_dw_cyc != 2) begin
                errors++;
                $display("FAIL cmplt_gap got=%0d exp=2", cyc - last_dw_cyc);
            end
        end
        if (frame_err) begin
            n_err++;
            checks++;
            if (wr_block || set_target || status_go || host_break ||
                go_reconfig || uart_cou_dword_en || link_rx_wr_cmplt) begin
                errors++;
                $display("FAIL err_coincident got=1 exp=0");
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_h);
        sample();
        @(posedge clk_h);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Sends SOF/OPC/LEN/pay (+CHK) and queues the expected results
    task automatic send_frame(input logic [7:0] opc, input logic [7:0] len);
        logic [7:0] x;
        x = opc ^ len;
        if (opc == 8'h05) exp_hash.push_back(pay[0]);
        else
            for (int j = 0; j < pay.size() / 4; j++)
                exp_dw.push_back({pay[4*j+3], pay[4*j+2], pay[4*j+1], pay[4*j]});
        send_byte(8'h55);
        send_byte(opc);
        send_byte(len);
        for (int i = 0; i < pay.size(); i++) begin
            send_byte(pay[i]);
            x = x ^ pay[i];
        end
`ifdef HOST_CMD_CHKSUM_EN
        send_byte(x);
`endif
    endtask

    task automatic test_reset();
        rst_h = 1'b1;
        idle(3);
        checks++;
        if ({wr_block, set_target, status_go, host_break, go_reconfig,
             uart_cou_dword_en, link_rx_wr_cmplt, frame_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_pulses got=nonzero exp=0");
        end
        rst_h = 1'b0;
        idle(2);
        checks++;
        if (data_from_host !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=0", data_from_host);
        end
        checks++;
        if (hash_frequency !== 8'h00) begin
            errors++;
            $display("FAIL reset_hash got=%h exp=00", hash_frequency);
        end
        checks++;
        if (err_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_err_cnt got=%h exp=00", err_cnt);
        end
    endtask

    task automatic test_wr_block();
        clr_counts();
        pay.delete();
        for (int i = 0; i < 80; i++) pay.push_back(8'(i));
        send_frame(8'h01, 8'h14);
        idle(8);
        checks++;
        if (n_wr != 1 || n_st != 0) begin
            errors++;
            $display("FAIL wr_hdr got=%0d/%0d exp=1/0", n_wr, n_st);
        end
        checks++;
        if (n_dw != 20 || exp_dw.size() != 0) begin
            errors++;
            $display("FAIL wr_dwords got=%0d exp=20", n_dw);
        end
        checks++;
        if (n_cmplt != 1 || n_err != 0) begin
            errors++;
            $display("FAIL wr_cmplt got=%0d err=%0d exp=1/0", n_cmplt, n_err);
        end
        checks++;
        if (first_dw_cyc <= hdr_cyc) begin
            errors++;
            $display("FAIL wr_hdr_order got=%0d exp>%0d", first_dw_cyc, hdr_cyc);
        end
    endtask

    task automatic test_set_target();
        clr_counts();
        pay.delete();
        for (int i = 0; i < 32; i++) pay.push_back(8'h40 + 8'(i));
        send_frame(8'h02, 8'h08);
        idle(8);
        checks++;
        if (n_st != 1 || n_wr != 0) begin
            errors++;
            $display("FAIL st_hdr got=%0d/%0d exp=1/0", n_st, n_wr);
        end
        checks++;
        if (n_dw != 8 || n_cmplt != 1 || exp_dw.size() != 0) begin
            errors++;
            $display("FAIL st_data got=%0d/%0d exp=8/1", n_dw, n_cmplt);
        end
    endtask

    task automatic test_reconfig_status();
        clr_counts();
        pay.delete();
        pay.push_back(8'h2A);
        repeat (3) pay.push_back(8'h00);
        send_frame(8'h05, 8'h01);
        idle(4);
        checks++;
        if (n_rcf != 1 || n_dw != 0 || n_cmplt != 0 || exp_hash.size() != 0) begin
            errors++;
            $display("FAIL rcf got=%0d/%0d/%0d exp=1/0/0", n_rcf, n_dw, n_cmplt);
        end
        checks++;
        if (hash_frequency !== 8'h2A) begin
            errors++;
            $display("FAIL rcf_hold got=%h exp=2a", hash_frequency);
        end
        pay.delete();
        send_frame(8'h03, 8'h00);
        idle(4);
        checks++;
        if (n_status != 1 || n_err != 0) begin
            errors++;
            $display("FAIL status got=%0d exp=1", n_status);
        end
    endtask

    task automatic test_errors();
        clr_counts();
        send_byte(8'h55); send_byte(8'h09); send_byte(8'h00);
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h13);
        exp_err_cnt += 2;
        idle(4);
        checks++;
        if (n_err != 2 || err_cnt !== 8'(exp_err_cnt)) begin
            errors++;
            $display("FAIL bad_frames got=%0d cnt=%0d exp=2/%0d", n_err, err_cnt, exp_err_cnt);
        end
        checks++;
        if (n_wr + n_st + n_status + n_brk + n_rcf + n_dw != 0) begin
            errors++;
            $display("FAIL bad_frames_pulses got=nonzero exp=0");
        end
    endtask

    task automatic test_timeout();
        clr_counts();
        exp_dw.push_back(32'h03020100);
        exp_dw.push_back(32'h07060504);
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h14);
        for (int i = 0; i < 10; i++) send_byte(8'(i));
        idle(TMO + 10);
        exp_err_cnt++;
        checks++;
        if (n_err != 1 || n_dw != 2 || n_cmplt != 0) begin
            errors++;
            $display("FAIL timeout got=%0d/%0d/%0d exp=1/2/0", n_err, n_dw, n_cmplt);
        end
        checks++;
        if (err_cnt !== 8'(exp_err_cnt)) begin
            errors++;
            $display("FAIL timeout_cnt got=%0d exp=%0d", err_cnt, exp_err_cnt);
        end
        clr_counts();
        pay.delete();
        for (int i = 0; i < 32; i++) pay.push_back(8'hA0 + 8'(i));
        send_frame(8'h02, 8'h08);
        idle(8);
        checks++;
        if (n_dw != 8 || n_cmplt != 1 || n_err != 0) begin
            errors++;
            $display("FAIL post_timeout got=%0d/%0d exp=8/1", n_dw, n_cmplt);
        end
    endtask

    task automatic test_back_to_back();
        clr_counts();
        pay.delete();
        for (int i = 0; i < 32; i++) pay.push_back(8'($urandom_range(0, 255)));
        send_frame(8'h02, 8'h08);
        send_byte(8'h55); send_byte(8'h07);
        pay.delete();
        send_frame(8'h03, 8'h00);
        exp_err_cnt++;
        idle(8);
        checks++;
        if (n_dw != 8 || n_cmplt != 1 || n_status != 1 || n_err != 1) begin
            errors++;
            $display("FAIL b2b got=%0d/%0d/%0d/%0d exp=8/1/1/1", n_dw, n_cmplt, n_status, n_err);
        end
        checks++;
        if (err_cnt !== 8'(exp_err_cnt)) begin
            errors++;
            $display("FAIL b2b_cnt got=%0d exp=%0d", err_cnt, exp_err_cnt);
        end
    endtask

`ifdef HOST_CMD_CHKSUM_EN
    task automatic test_chksum();
        clr_counts();
        send_byte(8'h55); send_byte(8'h04); send_byte(8'h00); send_byte(8'h04);
        idle(4);
        checks++;
        if (n_brk != 1 || n_err != 0) begin
            errors++;
            $display("FAIL chk_ok got=%0d/%0d exp=1/0", n_brk, n_err);
        end
        clr_counts();
        send_byte(8'h55); send_byte(8'h04); send_byte(8'h00); send_byte(8'h05);
        exp_err_cnt++;
        idle(4);
        checks++;
        if (n_brk != 0 || n_err != 1 || err_cnt !== 8'(exp_err_cnt)) begin
            errors++;
            $display("FAIL chk_bad got=%0d/%0d exp=0/1", n_brk, n_err);
        end
    endtask
`endif

    task automatic test_reset_mid();
        clr_counts();
        exp_dw.push_back(32'h03020100);
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h14);
        for (int i = 0; i < 6; i++) send_byte(8'(i));
        idle(1);
        clr_counts();
        rst_h = 1'b1;
        idle(3);
        rst_h = 1'b0;
        exp_err_cnt = 0;
        idle(3);
        checks++;
        if (n_wr + n_st + n_status + n_brk + n_rcf + n_dw + n_cmplt + n_err != 0) begin
            errors++;
            $display("FAIL rst_mid_pulses got=nonzero exp=0");
        end
        checks++;
        if (err_cnt !== 8'h00 || hash_frequency !== 8'h00 || data_from_host !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_regs got=%h/%h/%h exp=0", err_cnt, hash_frequency, data_from_host);
        end
        clr_counts();
        pay.delete();
        for (int i = 0; i < 32; i++) pay.push_back(8'hC0 + 8'(i));
        send_frame(8'h02, 8'h08);
        idle(8);
        checks++;
        if (n_dw != 8 || n_cmplt != 1 || exp_dw.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_next got=%0d/%0d exp=8/1", n_dw, n_cmplt);
        end
    endtask

    task automatic test_err_saturate();
        clr_counts();
        for (int i = 0; i < 260; i++) begin
            send_byte(8'h55);
            send_byte(8'h09);
        end
        idle(4);
        checks++;
        if (err_cnt !== 8'hFF || n_err != 260) begin
            errors++;
            $display("FAIL err_sat got=%h/%0d exp=ff/260", err_cnt, n_err);
        end
    endtask

    initial begin
        clr_counts();
        test_reset();
        test_wr_block();
        test_set_target();
        test_reconfig_status();
        test_errors();
        test_timeout();
        test_back_to_back();
`ifdef HOST_CMD_CHKSUM_EN
        test_chksum();
`endif
        test_reset_mid();
        test_err_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
